// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, slave address map and output-stage state encoding
package bus_pkg;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int SLV_ADDR0 = 0;
  localparam int SLV_ADDR1 = 1;
  localparam int SLV_ADDR2 = 2;
  localparam int SLV_ADDR3 = 3;
  localparam int SLV_ADDR4 = 4;
  typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_GAPWAIT} out_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: pointer-based FIFO; the extra pointer bit separates full from empty
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DATA_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/bus_slave_fifo.sv
// bus_slave_fifo: captures one write per selected bus tenure into a FIFO and
// streams it out over valid/ready with an optional idle gap between beats
module bus_slave_fifo #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W,
  parameter int SLAVE_ADDR = bus_pkg::SLV_ADDR0,
  parameter int DEPTH = 4,
  parameter int GAP = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   busbusy,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      outdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   ack,
  output logic                   drop,
  output logic [7:0]             drop_cnt
);
  import bus_pkg::*;
  out_state_e state, state_nxt;
  logic sel, sel_q, wr, push, pop, empty;
  logic [DATA_W-1:0] head;
  logic [3:0] gap_cnt, gap_nxt;
  // if-form so an unknown address compare resolves to "not selected"
  always_comb begin
    sel = 1'b0;
    if (busbusy && address == ADDR_W'(SLAVE_ADDR)) sel = 1'b1;
  end
  assign wr = sel & ~sel_q;
  assign push = wr & (~full | pop);
  assign out_valid = state == ST_HOLD;
  // GAPWAIT releases on the edge where the counter steps 1->0, giving GAP idle cycles
  always_comb begin
    state_nxt = state;
    gap_nxt = gap_cnt;
    pop = 1'b0;
    case (state)
      ST_EMPTY: begin
        pop = ~empty;
        state_nxt = empty ? ST_EMPTY : ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready && GAP != 0) begin
          state_nxt = ST_GAPWAIT;
          gap_nxt = 4'(GAP);
        end else if (out_ready) begin
          pop = ~empty;
          state_nxt = empty ? ST_EMPTY : ST_HOLD;
        end
      end
      ST_GAPWAIT: begin
        gap_nxt = gap_cnt - 1'b1;
        if (gap_cnt == 4'd1) begin
          pop = ~empty;
          state_nxt = empty ? ST_EMPTY : ST_HOLD;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= 1'b0;
      state <= ST_EMPTY;
      gap_cnt <= '0;
      outdata <= '0;
      ack <= 1'b0;
      drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sel_q <= sel;
      state <= state_nxt;
      gap_cnt <= gap_nxt;
      if (pop) outdata <= head;
      ack <= push;
      drop <= wr & ~push;
      if (wr && !push && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(data),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_bus_slave_fifo.sv
// tb_bus_slave_fifo: directed scenario tasks for bus_slave_fifo (GAP=0 and GAP=2 instances)
module tb_bus_slave_fifo;
  logic clk = 1'b0;
  logic rst, busbusy, out_ready;
  logic [2:0] address;
  logic [7:0] data;
  logic out_valid, full, ack, drop;
  logic [7:0] outdata, drop_cnt;
  logic [2:0] count;
  logic g_out_valid, g_full, g_ack, g_drop;
  logic [7:0] g_outdata, g_drop_cnt;
  logic [2:0] g_count;
  int checks = 0, failures = 0;
  int ack_n, drop_n, g_ack_n, g_drop_n;
  logic [7:0] beats[$];
  logic [7:0] gbeats[$];
  always #5 clk = ~clk;
  bus_slave_fifo #(.ADDR_W(3), .DATA_W(8), .SLAVE_ADDR(2), .DEPTH(4), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .busbusy(busbusy), .address(address), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .outdata(outdata), .count(count),
    .full(full), .ack(ack), .drop(drop), .drop_cnt(drop_cnt)
  );
  bus_slave_fifo #(.ADDR_W(3), .DATA_W(8), .SLAVE_ADDR(2), .DEPTH(4), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .busbusy(busbusy), .address(address), .data(data),
    .out_valid(g_out_valid), .out_ready(out_ready), .outdata(g_outdata), .count(g_count),
    .full(g_full), .ack(g_ack), .drop(g_drop), .drop_cnt(g_drop_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
    if (ack) ack_n++;
    if (drop) drop_n++;
    if (g_ack) g_ack_n++;
    if (g_drop) g_drop_n++;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    busbusy = 1'b0;
    address = 'z;
    data = 'z;
    out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    ack_n = 0; drop_n = 0; g_ack_n = 0; g_drop_n = 0;
  endtask
  task automatic write_tenure(input logic [2:0] a, input logic [7:0] d, input int len);
    busbusy = 1'b1;
    address = a;
    data = d;
    repeat (len) tick();
    busbusy = 1'b0;
    address = 'z;
    data = 'z;
    tick();
  endtask
  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) begin
      if (out_valid) beats.push_back(outdata);
      tick();
    end
  endtask
  task automatic test_reset();
    do_reset();
    busbusy = 1'b1; address = 3'd2; data = 8'h3C; out_ready = 1'b0;
    tick(); tick();
    checks++; if (outdata !== 8'h3C) begin failures++; $display("FAIL pre_reset_outdata got=%h exp=3c", outdata); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (outdata !== 8'h00) begin failures++; $display("FAIL reset_outdata got=%h exp=00", outdata); end
    checks++; if ({count, full, ack, drop} !== 6'b0) begin failures++; $display("FAIL reset_flags got=%b exp=000000", {count, full, ack, drop}); end
    checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL reset_drop_cnt got=%h exp=00", drop_cnt); end
    busbusy = 1'b0; address = 'z; data = 'z;
    tick();
    rst = 1'b1;
    ack_n = 0;
    repeat (4) tick();
    checks++; if (ack_n !== 0) begin failures++; $display("FAIL idle_no_ack got=%0d exp=0", ack_n); end
  endtask
  task automatic test_reset_mid_tenure();
    busbusy = 1'b1; address = 3'd2; data = 8'h5A; out_ready = 1'b1;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    ack_n = 0;
    repeat (5) tick();
    checks++; if (ack_n !== 1) begin failures++; $display("FAIL mid_tenure_ack got=%0d exp=1", ack_n); end
    busbusy = 1'b0; address = 'z; data = 'z;
    repeat (3) tick();
  endtask
  task automatic test_single_write();
    int pulses, first;
    logic [7:0] vdata;
    do_reset();
    pulses = 0; first = -1; vdata = 8'h00;
    out_ready = 1'b1; busbusy = 1'b1; address = 3'd2; data = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin busbusy = 1'b0; address = 'z; data = 'z; end
      tick();
      if (out_valid) begin
        pulses++;
        vdata = outdata;
        if (first < 0) first = i + 1;
      end
    end
    checks++; if (ack_n !== 1) begin failures++; $display("FAIL single_ack got=%0d exp=1", ack_n); end
    checks++; if (pulses !== 1) begin failures++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    checks++; if (first !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", first); end
    checks++; if (vdata !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", vdata); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int d = 1; d <= 7; d++) write_tenure(3'd2, 8'(d), 2);
    checks++; if (ack_n !== 5) begin failures++; $display("FAIL ovf_acks got=%0d exp=5", ack_n); end
    checks++; if (drop_n !== 2) begin failures++; $display("FAIL ovf_drops got=%0d exp=2", drop_n); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=2", drop_cnt); end
    checks++; if ({full, count} !== 4'b1100) begin failures++; $display("FAIL ovf_full_count got=%b exp=1100", {full, count}); end
    beats.delete();
    drain(12);
    checks++; if (beats.size() !== 5) begin failures++; $display("FAIL ovf_beat_count got=%0d exp=5", beats.size()); end
    for (int i = 0; i < beats.size() && i < 5; i++) begin
      checks++; if (beats[i] !== 8'(i + 1)) begin failures++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, beats[i], 8'(i + 1)); end
    end
    checks++; if ({out_valid, count} !== 4'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0000", {out_valid, count}); end
  endtask
  task automatic test_backpressure();
    do_reset();
    write_tenure(3'd2, 8'h11, 1);
    write_tenure(3'd2, 8'h22, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({out_valid, outdata} !== 9'h111) begin failures++; $display("FAIL bp_hold%0d got=%b_%h exp=1_11", i, out_valid, outdata); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL bp_count%0d got=%0d exp=1", i, count); end
    end
  endtask
  task automatic test_full_simul();
    do_reset();
    for (int k = 0; k < 5; k++) write_tenure(3'd2, 8'hA1 + 8'(k), 1);
    checks++; if ({out_valid, full, count} !== 5'b11100) begin failures++; $display("FAIL fs_pre got=%b exp=11100", {out_valid, full, count}); end
    beats.delete();
    beats.push_back(outdata);
    busbusy = 1'b1; address = 3'd2; data = 8'h77; out_ready = 1'b1;
    ack_n = 0; drop_n = 0;
    tick();
    checks++; if (ack_n !== 1 || drop_n !== 0) begin failures++; $display("FAIL fs_ack_drop got=%0d/%0d exp=1/0", ack_n, drop_n); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fs_count got=%0d exp=4", count); end
    busbusy = 1'b0; address = 'z; data = 'z;
    drain(12);
    checks++; if (beats.size() !== 6) begin failures++; $display("FAIL fs_beat_count got=%0d exp=6", beats.size()); end
    checks++; if (beats.size() > 1 && beats[1] !== 8'hA2) begin failures++; $display("FAIL fs_second got=%h exp=a2", beats[1]); end
    checks++; if (beats.size() == 0 || beats[beats.size()-1] !== 8'h77) begin failures++; $display("FAIL fs_last got=%h exp=77", beats.size() == 0 ? 8'h00 : beats[beats.size()-1]); end
  endtask
  task automatic test_gap();
    logic [13:0] pat;
    int a0, g0;
    do_reset();
    for (int k = 0; k < 4; k++) write_tenure(3'd2, 8'h31 + 8'(k), 1);
    a0 = ack_n; g0 = g_ack_n;
    write_tenure(3'd3, 8'hEE, 2);
    checks++; if (ack_n !== a0 || g_ack_n !== g0) begin failures++; $display("FAIL gap_other_addr got=%0d/%0d exp=%0d/%0d", ack_n, g_ack_n, a0, g0); end
    checks++; if ({g_out_valid, g_count} !== 4'b1011) begin failures++; $display("FAIL gap_pre got=%b exp=1011", {g_out_valid, g_count}); end
    gbeats.delete();
    pat = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      pat[i] = g_out_valid;
      if (g_out_valid) gbeats.push_back(g_outdata);
      tick();
    end
    checks++; if (pat !== 14'h0249) begin failures++; $display("FAIL gap_pattern got=%b exp=%b", pat, 14'h0249); end
    checks++; if (gbeats.size() !== 4) begin failures++; $display("FAIL gap_beat_count got=%0d exp=4", gbeats.size()); end
    for (int i = 0; i < gbeats.size() && i < 4; i++) begin
      checks++; if (gbeats[i] !== 8'h31 + 8'(i)) begin failures++; $display("FAIL gap_beat%0d got=%h exp=%h", i, gbeats[i], 8'h31 + 8'(i)); end
    end
    checks++; if (g_drop_n !== 0 || g_drop_cnt !== 8'd0 || g_full !== 1'b0) begin failures++; $display("FAIL gap_no_drop got=%0d/%0d/%b exp=0/0/0", g_drop_n, g_drop_cnt, g_full); end
  endtask
  initial begin
    test_reset();
    test_reset_mid_tenure();
    test_single_write();
    test_overflow();
    test_backpressure();
    test_full_simul();
    test_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
